// File: rtl/hs_pkg.sv
// hs_pkg: shared types and width helpers for the click FIFO
package hs_pkg;
  typedef enum logic {FOUR_PHASE, TWO_PHASE} phase_mode_e;
  typedef enum logic [1:0] {IDLE, WAIT, REQ, RTZ} out_state_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/hs_sync.sv
// hs_sync: reset-to-zero flop chain for one handshake input, pass-through when STAGES is 0
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  if (STAGES == 0) begin : g_pass
    assign q = d;
  end else begin : g_ff
    logic [STAGES-1:0] r;
    // shift the raw input in at the low end, oldest sample at the top
    always_ff @(posedge clk)
      r <= reset ? '0 : STAGES'({r, d});
    assign q = r[STAGES-1];
  end
endmodule

// File: rtl/click_fifo_sync.sv
// click_fifo_sync: req/ack bundled-data channels bridged through a synchronous FIFO with delayed output request
module click_fifo_sync
  import hs_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int FL_DELAY    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int PHASE_MODE  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lreq,
  output logic                       lack,
  input  logic [WIDTH-1:0]           ldata,
  output logic                       rreq,
  input  logic                       rack,
  output logic [WIDTH-1:0]           rdata,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       full,
  output logic                       empty
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int DW = $clog2(FL_DELAY + 2);
  localparam bit two_ph = PHASE_MODE == int'(TWO_PHASE);
  localparam logic [PW-1:0] last = PW'(DEPTH - 1);
  localparam logic [DW-1:0] dly_init = DW'(FL_DELAY > 0 ? FL_DELAY - 1 : 0);
  logic lreq_s, rack_s, push, pop, go_req;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] dly_cnt;
  out_state_e state;
  hs_sync #(.STAGES(SYNC_STAGES)) u_lreq_sync (.clk(clk), .reset(reset), .d(lreq), .q(lreq_s));
  hs_sync #(.STAGES(SYNC_STAGES)) u_rack_sync (.clk(clk), .reset(reset), .d(rack), .q(rack_s));
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  // handshake decode: full uses the pre-pop count, so a same-cycle pop never frees a slot early
  always_comb begin
    push   = !full && (two_ph ? lreq_s != lack : lreq_s && !lack);
    pop    = state == REQ && (two_ph ? rack_s == rreq : rack_s);
    go_req = (state == IDLE && !empty && FL_DELAY == 0) || (state == WAIT && dly_cnt == '0);
  end
  // input side: capture raw ldata and answer the request
  always_ff @(posedge clk)
    if (reset) begin
      lack   <= 1'b0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= ldata;
      lack        <= two_ph ? ~lack : 1'b1;
      wr_ptr      <= wr_ptr == last ? '0 : wr_ptr + 1'b1;
    end else if (!two_ph && !lreq_s && lack)
      lack <= 1'b0;
  // occupancy: push and pop in the same cycle cancel
  always_ff @(posedge clk)
    count <= reset ? '0 : count + CW'(push) - CW'(pop);
  // output FSM: forward-latency wait, then present the head entry until it is acknowledged
  always_ff @(posedge clk)
    if (reset) begin
      state   <= IDLE;
      rreq    <= 1'b0;
      rdata   <= '0;
      rd_ptr  <= '0;
      dly_cnt <= '0;
    end else if (go_req) begin
      state <= REQ;
      rdata <= mem[rd_ptr];
      rreq  <= two_ph ? ~rreq : 1'b1;
    end else if (state == IDLE && !empty) begin
      state   <= WAIT;
      dly_cnt <= dly_init;
    end else if (state == WAIT)
      dly_cnt <= dly_cnt - 1'b1;
    else if (pop) begin
      rd_ptr <= rd_ptr == last ? '0 : rd_ptr + 1'b1;
      state  <= two_ph ? IDLE : RTZ;
      rreq   <= two_ph ? rreq : 1'b0;
    end else if (state == RTZ && !rack_s)
      state <= IDLE;
endmodule
